// File: rtl/fsm_trace_pkg.sv
// Shared constants and helpers for the FSM trace reader slice.
// Holds the state encodings and the index-width helper.
package fsm_trace_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Index width for n history entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fsm_trace_first_valid.sv
// Combinational search for the oldest (highest-index) nonzero history entry.
// Reports index 0 and all_zero=1 when every entry is zero.
module fsm_trace_first_valid
    import fsm_trace_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [W*N-1:0] snapshot,
    output logic [IW-1:0]  index,
    output logic           all_zero
);

    always_comb begin
        index    = '0;
        all_zero = 1'b1;
        // Ascending scan: the last match is the highest nonzero index.
        for (int unsigned i = 0; i < N; i++) begin
            if (snapshot[i*W +: W] != '0) begin
                index    = IW'(i);
                all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fsm_trace_reader.sv
// Captures a packed state-history vector on request and streams its entries
// oldest-first over a valid/ready interface, counting requests made while busy.
module fsm_trace_reader
    import fsm_trace_pkg::*;
#(
    parameter int unsigned INTSTATE_WIDTH        = 8,
    parameter int unsigned INTSTATE_VECTOR_WIDTH = 32,
    parameter bit          TRIM_UNFILLED         = 1'b1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [INTSTATE_VECTOR_WIDTH-1:0]    state_vector_in,
    input  logic                                snap_req,
    output logic                                busy,
    output logic                                hist_valid,
    input  logic                                hist_ready,
    output logic [INTSTATE_WIDTH-1:0]           hist_data,
    output logic [idx_width(INTSTATE_VECTOR_WIDTH/INTSTATE_WIDTH)-1:0] hist_index,
    output logic                                hist_last,
    output logic                                snap_done,
    output logic [7:0]                          drop_count
);

    localparam int unsigned W  = INTSTATE_WIDTH;
    localparam int unsigned VW = INTSTATE_VECTOR_WIDTH;
    localparam int unsigned N  = VW / W;
    localparam int unsigned IW = idx_width(N);

    if ((VW % W) != 0) begin : g_width_check
        $error("INTSTATE_VECTOR_WIDTH must be a multiple of INTSTATE_WIDTH");
    end

    logic [1:0]    state_q, state_d;
    logic [VW-1:0] snap_q,  snap_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [W-1:0]  data_q,  data_d;
    logic          last_q,  last_d;
    logic          valid_q, valid_d;
    logic [7:0]    drop_q,  drop_d;

    logic [IW-1:0] found_idx;
    logic          all_zero;
    logic [IW-1:0] start_idx;
    logic [IW-1:0] sel_idx;
    logic [W-1:0]  sel_data;

    fsm_trace_first_valid #(
        .W  (W),
        .N  (N),
        .IW (IW)
    ) u_first_valid (
        .snapshot (snap_q),
        .index    (found_idx),
        .all_zero (all_zero)
    );

    always_comb begin
        start_idx = TRIM_UNFILLED ? found_idx : IW'(N - 1);
        if (all_zero) begin
            start_idx = '0;
        end
        // One mux serves both the first beat and every subsequent beat.
        sel_idx  = (state_q == ST_SCAN) ? start_idx : (idx_q - IW'(1));
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel_idx == IW'(i)) begin
                sel_data = snap_q[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        drop_d  = drop_q;

        if (snap_req && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (snap_req) begin
                    snap_d  = state_vector_in;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                idx_d   = sel_idx;
                data_d  = sel_data;
                last_d  = (sel_idx == '0);
                valid_d = 1'b1;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (valid_q && hist_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d  = sel_idx;
                        data_d = sel_data;
                        last_d = (sel_idx == '0);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign snap_done  = (state_q == ST_DONE);
    assign hist_valid = valid_q;
    assign hist_data  = data_q;
    assign hist_index = idx_q;
    assign hist_last  = last_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_fsm_trace_reader.sv
// Directed bench for fsm_trace_reader (W=8, VW=32, N=4), trimming and non-trimming.
module tb_fsm_trace_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] state_vector_in;
    logic        snap_req;
    logic        hist_ready;
    logic        ready2;

    logic        busy, hist_valid, hist_last, snap_done;
    logic [7:0]  hist_data, drop_count;
    logic [1:0]  hist_index;

    logic        busy2, hist_valid2, hist_last2, snap_done2;
    logic [7:0]  hist_data2, drop_count2;
    logic [1:0]  hist_index2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fsm_trace_reader #(
        .INTSTATE_WIDTH        (8),
        .INTSTATE_VECTOR_WIDTH (32),
        .TRIM_UNFILLED         (1'b1)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .state_vector_in (state_vector_in),
        .snap_req        (snap_req),
        .busy            (busy),
        .hist_valid      (hist_valid),
        .hist_ready      (hist_ready),
        .hist_data       (hist_data),
        .hist_index      (hist_index),
        .hist_last       (hist_last),
        .snap_done       (snap_done),
        .drop_count      (drop_count)
    );

    fsm_trace_reader #(
        .INTSTATE_WIDTH        (8),
        .INTSTATE_VECTOR_WIDTH (32),
        .TRIM_UNFILLED         (1'b0)
    ) u_dut_notrim (
        .clk             (clk),
        .reset           (reset),
        .state_vector_in (state_vector_in),
        .snap_req        (snap_req),
        .busy            (busy2),
        .hist_valid      (hist_valid2),
        .hist_ready      (ready2),
        .hist_data       (hist_data2),
        .hist_index      (hist_index2),
        .hist_last       (hist_last2),
        .snap_done       (snap_done2),
        .drop_count      (drop_count2)
    );

    // {valid, data, index, last}
    function automatic logic [11:0] beat(input logic [7:0] d, input logic [1:0] i, input logic l);
        return {1'b1, d, i, l};
    endfunction

    wire [11:0] act  = {hist_valid, hist_data, hist_index, hist_last};
    wire [11:0] act2 = {hist_valid2, hist_data2, hist_index2, hist_last2};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [31:0] vec);
        state_vector_in = vec;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; snap_req = 1'b0; hist_ready = 1'b1; ready2 = 1'b1;
        state_vector_in = 32'h0;
        tick(); tick();
        reset = 1'b0;
        tests_run++;
        if ({busy, snap_done, drop_count} !== 10'h0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got busy=%b done=%b drop=%0d exp 0", busy, snap_done, drop_count);
        end
        tests_run++;
        if (act !== 12'h0) begin
            tests_failed++;
            $display("FAIL reset_stream got %h exp 000", act);
        end
    endtask

    task automatic test_basic();
        logic [11:0] exp [4];
        exp[0] = beat(8'h04, 2'd3, 1'b0); exp[1] = beat(8'h03, 2'd2, 1'b0);
        exp[2] = beat(8'h02, 2'd1, 1'b0); exp[3] = beat(8'h01, 2'd0, 1'b1);
        hist_ready = 1'b1;
        pulse_req(32'h04030201);
        tests_run++;
        if ({busy, hist_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL basic_scan got busy=%b valid=%b exp busy=1 valid=0", busy, hist_valid);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (act !== exp[k]) begin
                tests_failed++;
                $display("FAIL basic_beat%0d got %h exp %h", k, act, exp[k]);
            end
            tick();
        end
        tests_run++;
        if ({hist_valid, snap_done, busy} !== 3'b011) begin
            tests_failed++;
            $display("FAIL basic_done got valid=%b done=%b busy=%b exp 0,1,1", hist_valid, snap_done, busy);
        end
        tick();
        tests_run++;
        if ({snap_done, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL basic_idle got done=%b busy=%b exp 0,0", snap_done, busy);
        end
        tick();
    endtask

    task automatic test_trim();
        logic [11:0] exp2 [4];
        exp2[0] = beat(8'h00, 2'd3, 1'b0); exp2[1] = beat(8'h00, 2'd2, 1'b0);
        exp2[2] = beat(8'h02, 2'd1, 1'b0); exp2[3] = beat(8'h01, 2'd0, 1'b1);
        hist_ready = 1'b1;
        pulse_req(32'h00000201);
        tick();
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (act2 !== exp2[k]) begin
                tests_failed++;
                $display("FAIL notrim_beat%0d got %h exp %h", k, act2, exp2[k]);
            end
            if (k == 0) begin
                tests_run++;
                if (act !== beat(8'h02, 2'd1, 1'b0)) begin
                    tests_failed++;
                    $display("FAIL trim_beat0 got %h exp %h", act, beat(8'h02, 2'd1, 1'b0));
                end
            end else if (k == 1) begin
                tests_run++;
                if (act !== beat(8'h01, 2'd0, 1'b1)) begin
                    tests_failed++;
                    $display("FAIL trim_beat1 got %h exp %h", act, beat(8'h01, 2'd0, 1'b1));
                end
            end else if (k == 2) begin
                tests_run++;
                if ({hist_valid, snap_done} !== 2'b01) begin
                    tests_failed++;
                    $display("FAIL trim_done got valid=%b done=%b exp 0,1", hist_valid, snap_done);
                end
            end
            tick();
        end
        tests_run++;
        if ({hist_valid2, snap_done2} !== 2'b01) begin
            tests_failed++;
            $display("FAIL notrim_done got valid=%b done=%b exp 0,1", hist_valid2, snap_done2);
        end
        tick(); tick();
    endtask

    task automatic test_zero();
        hist_ready = 1'b1;
        pulse_req(32'h00000000);
        tick();
        tests_run++;
        if (act !== beat(8'h00, 2'd0, 1'b1)) begin
            tests_failed++;
            $display("FAIL zero_beat got %h exp %h", act, beat(8'h00, 2'd0, 1'b1));
        end
        tick();
        tests_run++;
        if ({hist_valid, snap_done} !== 2'b01) begin
            tests_failed++;
            $display("FAIL zero_done got valid=%b done=%b exp 0,1", hist_valid, snap_done);
        end
        tick(); tick();
    endtask

    task automatic test_stall();
        hist_ready = 1'b1;
        pulse_req(32'h04030201);
        tick();
        tests_run++;
        if (act !== beat(8'h04, 2'd3, 1'b0)) begin
            tests_failed++;
            $display("FAIL stall_beat0 got %h exp %h", act, beat(8'h04, 2'd3, 1'b0));
        end
        tick();
        hist_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (act !== beat(8'h03, 2'd2, 1'b0)) begin
                tests_failed++;
                $display("FAIL stall_hold%0d got %h exp %h", j, act, beat(8'h03, 2'd2, 1'b0));
            end
            state_vector_in = $urandom;
            if (j == 3) hist_ready = 1'b1;
            else tick();
        end
        tick();
        tests_run++;
        if (act !== beat(8'h02, 2'd1, 1'b0)) begin
            tests_failed++;
            $display("FAIL stall_beat2 got %h exp %h", act, beat(8'h02, 2'd1, 1'b0));
        end
        tick();
        tests_run++;
        if (act !== beat(8'h01, 2'd0, 1'b1)) begin
            tests_failed++;
            $display("FAIL stall_beat3 got %h exp %h", act, beat(8'h01, 2'd0, 1'b1));
        end
        tick();
        tests_run++;
        if (snap_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_done got %b exp 1", snap_done);
        end
        tick(); tick();
    endtask

    task automatic test_drops();
        logic [11:0] exp [4];
        exp[0] = beat(8'h04, 2'd3, 1'b0); exp[1] = beat(8'h03, 2'd2, 1'b0);
        exp[2] = beat(8'h02, 2'd1, 1'b0); exp[3] = beat(8'h01, 2'd0, 1'b1);
        tests_run++;
        if (drop_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL drop_start got %0d exp 0", drop_count);
        end
        hist_ready = 1'b0;
        pulse_req(32'h04030201);
        for (int j = 0; j < 300; j++) begin
            snap_req = 1'b1;
            state_vector_in = $urandom;
            tick();
            snap_req = 1'b0;
            tick();
        end
        tests_run++;
        if (drop_count !== 8'd255) begin
            tests_failed++;
            $display("FAIL drop_sat got %0d exp 255", drop_count);
        end
        hist_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (act !== exp[k]) begin
                tests_failed++;
                $display("FAIL drop_beat%0d got %h exp %h", k, act, exp[k]);
            end
            tick();
        end
        tests_run++;
        if (snap_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_done got %b exp 1", snap_done);
        end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        int done_seen;
        hist_ready = 1'b1;
        pulse_req(32'h04030201);
        tick(); tick();
        reset = 1'b1;
        snap_req = 1'b1;
        tick();
        reset = 1'b0;
        snap_req = 1'b0;
        tests_run++;
        if ({act, busy, snap_done, drop_count} !== 22'h0) begin
            tests_failed++;
            $display("FAIL midreset_outs got stream=%h busy=%b done=%b drop=%0d exp 0",
                     act, busy, snap_done, drop_count);
        end
        done_seen = 0;
        for (int j = 0; j < 4; j++) begin
            if (snap_done === 1'b1 || busy === 1'b1) done_seen++;
            tick();
        end
        tests_run++;
        if (done_seen != 0) begin
            tests_failed++;
            $display("FAIL midreset_quiet got %0d active cycles exp 0", done_seen);
        end
        pulse_req(32'h00000201);
        tick();
        tests_run++;
        if (act !== beat(8'h02, 2'd1, 1'b0)) begin
            tests_failed++;
            $display("FAIL midreset_new0 got %h exp %h", act, beat(8'h02, 2'd1, 1'b0));
        end
        tick();
        tests_run++;
        if (act !== beat(8'h01, 2'd0, 1'b1)) begin
            tests_failed++;
            $display("FAIL midreset_new1 got %h exp %h", act, beat(8'h01, 2'd0, 1'b1));
        end
        tick();
        tests_run++;
        if (snap_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_done got %b exp 1", snap_done);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_trim();
        test_zero();
        test_stall();
        test_drops();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fsm_trace_reader.md
FSM_TRACE_READER -- requirements
Module: fsm_trace_reader

Interface
REQ-001 SHALL have parameter INTSTATE_WIDTH, default 8, meaning bits per history entry.
REQ-002 SHALL have parameter INTSTATE_VECTOR_WIDTH, default 32, meaning packed history width; entry count N = INTSTATE_VECTOR_WIDTH / INTSTATE_WIDTH.
REQ-003 SHALL have parameter TRIM_UNFILLED, default 1, meaning skip oldest all-zero (never-written) entries.
REQ-004 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port state_vector_in, input, INTSTATE_VECTOR_WIDTH; entry i occupies bits [i*W +: W]; entry 0 is newest, entry N-1 is oldest.
REQ-007 SHALL have port snap_req, input, 1, single-cycle snapshot request.
REQ-008 SHALL have port busy, output, 1, high from accepted request until snap_done.
REQ-009 SHALL have port hist_valid, input hist_ready, and outputs hist_data [W-1:0], hist_index [clog2(N)-1:0] and hist_last (1), forming a valid/ready entry stream.
REQ-010 SHALL have port snap_done, output, 1, one-cycle pulse after the last beat is accepted.
REQ-011 SHALL have port drop_count, output, 8, saturating count of rejected requests.

Function
REQ-012 SHALL use states IDLE, SCAN, STREAM and DONE.
REQ-013 In IDLE with snap_req=1 at edge T, SHALL register state_vector_in into a snapshot and enter SCAN; busy=1 from T+1.
REQ-014 SCAN SHALL last exactly one cycle and compute the start index: the highest i with a nonzero snapshot entry when TRIM_UNFILLED=1, otherwise N-1; an all-zero snapshot yields start index 0.
REQ-015 SHALL enter STREAM after SCAN; hist_valid=1 from T+2 carrying the start entry.
REQ-016 SHALL emit entries oldest-first, decrementing hist_index by one per accepted beat (hist_valid & hist_ready) down to 0.
REQ-017 hist_last SHALL be 1 only on the index-0 beat.
REQ-018 hist_data, hist_index and hist_last SHALL remain stable while hist_valid=1 and hist_ready=0.
REQ-019 hist_valid SHALL NOT depend combinationally on hist_ready; back-to-back beats SHALL sustain one per cycle while hist_ready=1.
REQ-020 On acceptance of the last beat, SHALL deassert hist_valid on the next cycle and enter DONE; DONE SHALL pulse snap_done for one cycle, then return to IDLE with busy=0.
REQ-021 snap_req while busy=1, including in the DONE cycle, SHALL be ignored for capture and SHALL increment drop_count; drop_count SHALL hold at 255.
REQ-022 state_vector_in changes after capture SHALL NOT affect the stream in progress.
REQ-023 A snap_req in the cycle following DONE (IDLE) SHALL be accepted normally.

Reset
REQ-024 On reset=1, outputs SHALL on the next edge be: busy=0, hist_valid=0, hist_data=0, hist_index=0, hist_last=0, snap_done=0, drop_count=0; state SHALL be IDLE and the snapshot cleared.
REQ-025 Reset asserted mid-STREAM SHALL abort the snapshot without a snap_done pulse; reset SHALL take priority over snap_req in the same cycle.

Structure
REQ-026 A shared package fsm_trace_pkg SHALL hold the state encoding constants and the index-width helper (clog2 of N, minimum 1).
REQ-027 The oldest-nonzero priority search SHALL be a sub-module fsm_trace_first_valid (snapshot in, index and all_zero out), combinational.
REQ-028 Elaboration SHALL fail when INTSTATE_VECTOR_WIDTH is not a multiple of INTSTATE_WIDTH.

Verification (W=8, VW=32, N=4)
REQ-029 Apply vector 0x04030201, snap_req, hist_ready=1 -> beats (0x04,3),(0x03,2),(0x02,1),(0x01,0,last) on consecutive cycles starting at T+2; snap_done one cycle after the last beat.
REQ-030 Apply vector 0x00000201 with TRIM_UNFILLED=1 -> beats (0x02,1),(0x01,0,last) only; with TRIM_UNFILLED=0 -> four beats starting with (0x00,3).
REQ-031 Apply vector 0x00000000 -> single beat (0x00,0,last), then snap_done.
REQ-032 Hold hist_ready=0 for 3 cycles on the second beat while toggling state_vector_in -> beat (0x03,2) stays stable, and the remaining beats match the captured snapshot.
REQ-033 Issue 300 snap_req pulses during one stalled stream -> drop_count=255, and the stream completes unaffected.
REQ-034 Assert reset in the middle of STREAM -> next cycle all outputs are 0, no snap_done pulse occurs, and a new snap_req is accepted normally.
